// File: rtl/mont_pkg.sv
// Shared types for the Montgomery multiplier slice.
// State encoding and counter sizing helper.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINAL
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mont_mult_unit_if.sv
// Start/done handshake bundle between operand mux and multiplier.
// master = caller, slave = mont_mult_unit.
interface mont_mult_unit_if #(
  parameter int WIDTH = 4
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, a, b, m,
    input  busy, done, result, err
  );

  modport slave (
    input  start, a, b, m,
    output busy, done, result, err
  );

endinterface

// File: rtl/mont_csub.sv
// Montgomery final conditional subtract: P in [0, 2m) -> [0, m).
// Purely combinational; shared with the exponentiation controller.
module mont_csub
  import mont_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] diff;

  always_comb begin
    m_ext = {1'b0, m};
    diff  = p - m_ext;
    r     = (p >= m_ext) ? diff[WIDTH-1:0]
                         : p[WIDTH-1:0];
  end

endmodule

// File: rtl/mont_mult_unit.sv
// Radix-2 bit-serial Montgomery multiplier: a*b*2^-WIDTH mod m.
// Build option MONT_MOD_CHECK_EN: reject even moduli with err.
module mont_mult_unit
  import mont_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  mont_mult_unit_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] m_reg;
  logic [WIDTH:0]   p;
  logic [CW-1:0]    i;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_fin;

  logic [WIDTH+1:0] t_add;
  logic [WIDTH+1:0] t_odd;
  logic [WIDTH:0]   p_nxt;

`ifdef MONT_MOD_CHECK_EN
  logic rej;
  logic err_q;
`endif

  // a is shifted right each iteration so bit 0 is always a_reg[i]
  always_comb begin
    t_add = {1'b0, p}
          + (a_sh[0] ? {2'b00, b_reg}
                     : {(WIDTH+2){1'b0}});
    t_odd = t_add[0] ? t_add + {2'b00, m_reg}
                     : t_add;
    p_nxt = t_odd[WIDTH+1:1];
  end

  mont_csub #(
    .WIDTH (WIDTH)
  ) u_csub (
    .p (p),
    .m (m_reg),
    .r (res_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      p      <= '0;
      i      <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      res_q  <= '0;
`ifdef MONT_MOD_CHECK_EN
      rej    <= 1'b0;
      err_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
`ifdef MONT_MOD_CHECK_EN
          if (rej) begin
            rej    <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
            res_q  <= '0;
          end else if (bus.start && !bus.m[0]) begin
            rej <= 1'b1;
          end else if (bus.start) begin
`else
          if (bus.start) begin
`endif
            a_sh   <= bus.a;
            b_reg  <= bus.b;
            m_reg  <= bus.m;
            p      <= '0;
            i      <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          p    <= p_nxt;
          a_sh <= a_sh >> 1;
          i    <= i + 1'b1;
          if (i == LAST) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          res_q  <= res_fin;
          done_q <= 1'b1;
          busy_q <= 1'b0;
`ifdef MONT_MOD_CHECK_EN
          err_q  <= 1'b0;
`endif
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = res_q;
`ifdef MONT_MOD_CHECK_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif

endmodule

// File: tb/tb_mont_mult_unit.sv
// Bench for mont_mult_unit: WIDTH=4 directed runs, WIDTH=8 random.
// Expected products are queued at start and popped at done.
module tb_mont_mult_unit;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mont_mult_unit_if #(.WIDTH(4)) bus4 ();
  mont_mult_unit_if #(.WIDTH(8)) bus8 ();

  mont_mult_unit #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  mont_mult_unit #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] q4[$];
  logic [7:0] q8[$];

  task automatic start4(input int a, input int b, input int m);
    bus4.start = 1'b1;
    bus4.a = 4'(a);
    bus4.b = 4'(b);
    bus4.m = 4'(m);
    @(negedge clk);
    bus4.start = 1'b0;
  endtask

  task automatic wait4(output int n);
    n = 0;
    while (bus4.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait8(output int n);
    n = 0;
    while (bus8.done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", bus4.busy);
    end
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b exp=0", bus4.done);
    end
    checks++;
    if (bus4.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got=%b exp=0", bus4.err);
    end
    checks++;
    if (bus4.result !== 4'd0) begin
      errors++;
      $display("FAIL reset_result got=%0d exp=0", bus4.result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    logic [3:0] exp;
    q4.push_back(4'd3);
    start4(5, 7, 13);
    checks++;
    if (bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got=%b exp=1", bus4.busy);
    end
    wait4(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL basic_latency got=%0d exp=5", n);
    end
    exp = q4.pop_front();
    checks++;
    if (bus4.result !== exp) begin
      errors++;
      $display("FAIL basic_result got=%0d exp=%0d", bus4.result, exp);
    end
    checks++;
    if (bus4.err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got=%b exp=0", bus4.err);
    end
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_done got=%b exp=0", bus4.busy);
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got=%b exp=0", bus4.done);
    end
  endtask

  task automatic test_vectors;
    int va[3] = '{1, 0, 12};
    int vb[3] = '{1, 11, 12};
    int ve[3] = '{9, 0, 9};
    int n;
    logic [3:0] exp;
    for (int k = 0; k < 3; k++) begin
      q4.push_back(4'(ve[k]));
      start4(va[k], vb[k], 13);
      wait4(n);
      checks++;
      if (n !== 5) begin
        errors++;
        $display("FAIL vec%0d_latency got=%0d exp=5", k, n);
      end
      exp = q4.pop_front();
      checks++;
      if (bus4.result !== exp) begin
        errors++;
        $display("FAIL vec%0d_result got=%0d exp=%0d",
                 k, bus4.result, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int dones;
    int at;
    logic [3:0] exp;
    q4.push_back(4'd3);
    start4(5, 7, 13);
    wait4(n);
    exp = q4.pop_front();
    checks++;
    if (bus4.result !== exp) begin
      errors++;
      $display("FAIL b2b_first got=%0d exp=%0d", bus4.result, exp);
    end
    q4.push_back(4'd3);
    start4(3, 3, 13);
    checks++;
    if (bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_no_gap got=%b exp=1", bus4.busy);
    end
    dones = 0;
    at = -1;
    for (int k = 0; k < 12; k++) begin
      bus4.start = (k == 1);
      bus4.a = 4'd1;
      bus4.b = 4'd1;
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        dones++;
        at = k;
        exp = (q4.size() > 0) ? q4.pop_front() : 4'hx;
        checks++;
        if (bus4.result !== exp) begin
          errors++;
          $display("FAIL b2b_second got=%0d exp=%0d",
                   bus4.result, exp);
        end
      end
    end
    bus4.start = 1'b0;
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d exp=1", dones);
    end
    checks++;
    if (at !== 4) begin
      errors++;
      $display("FAIL b2b_second_latency got=%0d exp=4", at);
    end
  endtask

  task automatic test_reset_abort;
    int n;
    int dones;
    logic [3:0] exp;
    start4(5, 7, 13);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got=%b exp=0", bus4.busy);
    end
    checks++;
    if (bus4.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done got=%b exp=0", bus4.done);
    end
    checks++;
    if (bus4.result !== 4'd0) begin
      errors++;
      $display("FAIL abort_result got=%0d exp=0", bus4.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done got=%0d exp=0", dones);
    end
    q4.push_back(4'd3);
    start4(5, 7, 13);
    wait4(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL abort_rerun_latency got=%0d exp=5", n);
    end
    exp = q4.pop_front();
    checks++;
    if (bus4.result !== exp) begin
      errors++;
      $display("FAIL abort_rerun got=%0d exp=%0d", bus4.result, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_mod_check;
    int n;
    logic [3:0] exp;
    start4(5, 7, 12);
    checks++;
    if (bus4.busy !== 1'b0 && bus4.busy !== 1'b1) begin
      errors++;
      $display("FAIL modchk_busy_x got=%b exp=0/1", bus4.busy);
    end
`ifdef MONT_MOD_CHECK_EN
    checks++;
    if (bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL modchk_busy got=%b exp=0", bus4.busy);
    end
    wait4(n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL modchk_latency got=%0d exp=1", n);
    end
    checks++;
    if (bus4.err !== 1'b1) begin
      errors++;
      $display("FAIL modchk_err got=%b exp=1", bus4.err);
    end
    checks++;
    if (bus4.result !== 4'd0) begin
      errors++;
      $display("FAIL modchk_result got=%0d exp=0", bus4.result);
    end
`else
    wait4(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL even_m_latency got=%0d exp=5", n);
    end
    checks++;
    if (bus4.err !== 1'b0) begin
      errors++;
      $display("FAIL even_m_err got=%b exp=0", bus4.err);
    end
`endif
    @(negedge clk);
    q4.push_back(4'd3);
    start4(5, 7, 13);
    wait4(n);
    exp = q4.pop_front();
    checks++;
    if (bus4.result !== exp || bus4.err !== 1'b0) begin
      errors++;
      $display("FAIL modchk_after got=%0d/%b exp=%0d/0",
               bus4.result, bus4.err, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int m;
    int a;
    int b;
    int rinv;
    int n;
    logic [7:0] exp;
    for (int r = 0; r < 2000; r++) begin
      m = ($urandom_range(1, 127) << 1) | 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      rinv = 0;
      for (int x = 1; x < m; x++) begin
        if ((256 * x) % m == 1) rinv = x;
      end
      q8.push_back(8'((((a * b) % m) * rinv) % m));
      bus8.start = 1'b1;
      bus8.a = 8'(a);
      bus8.b = 8'(b);
      bus8.m = 8'(m);
      @(negedge clk);
      bus8.start = 1'b0;
      wait8(n);
      checks++;
      if (n !== 9) begin
        errors++;
        $display("FAIL rand%0d_latency got=%0d exp=9", r, n);
      end
      exp = q8.pop_front();
      checks++;
      if (bus8.result !== exp) begin
        errors++;
        $display("FAIL rand%0d a=%0d b=%0d m=%0d got=%0d exp=%0d",
                 r, a, b, m, bus8.result, exp);
      end
    end
  endtask

  initial begin
    bus4.start = 1'b0;
    bus4.a = '0;
    bus4.b = '0;
    bus4.m = '0;
    bus8.start = 1'b0;
    bus8.a = '0;
    bus8.b = '0;
    bus8.m = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_mod_check();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mont_mult_unit.md
# mont_mult_unit

Radix-2 bit-serial Montgomery modular multiplier: computes result = a·b·2^(-WIDTH) mod m over WIDTH iterations plus one conditional-subtract cycle. It is the arithmetic stage directly downstream of the operand-select mux stage. The mux drives each operand with a, b, all-ones or zero, and this block consumes the selected operands under a start/done handshake. The exponentiation controller sequences repeated calls.

## Interface
- WIDTH, default 4: operand/modulus width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplier operand; caller guarantees a < m.
- b  input  WIDTH  multiplicand operand; caller guarantees b < m.
- m  input  WIDTH  modulus; must be odd.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when result is updated.
- result  output  WIDTH  last completed product; held until the next done.
- err  output  1  qualifies done: even modulus rejected (see Configuration).

## Operation
- States: IDLE, CALC, FINAL.
- IDLE:
  - start=1 latches a, b and m into internal registers, clears accumulator P and iteration counter i, and moves to CALC.
  - a, b and m are don't-care after the accepting edge.
- CALC, one iteration per clock, i = 0..WIDTH-1:
  - T = P + (a_reg[i] ? b_reg : 0).
  - If T is odd, T = T + m_reg.
  - P = T >> 1.
  - After iteration WIDTH-1, move to FINAL.
- FINAL:
  - result = (P ≥ m_reg) ? P − m_reg : P, truncated to WIDTH bits.
  - done=1 for one cycle, err=0; return to IDLE.
- Width rules:
  - P is WIDTH+1 bits (invariant P < 2m).
  - T is WIDTH+2 bits (T < 4m).
  - No overflow for legal inputs.
  - Illegal inputs (a ≥ m, b ≥ m) give an unspecified result but do not hang the FSM; done still fires on schedule.
- start during CALC or FINAL is ignored, with no queuing.
- start in the done cycle is accepted (FSM is in IDLE): back-to-back operation, zero dead cycles.

## Timing
- Reset values: busy=0, done=0, err=0, result='0, state=IDLE, P='0, i=0.
- Reset asserted mid-operation aborts immediately to the reset values. No done is produced for the aborted operation.
- Start accepted at edge E0. busy=1 from E0 through the edge that raises done. done is high for exactly the cycle after edge E0+WIDTH+1.
- Latency: WIDTH+1 clocks from the accepting edge to done. Throughput: one product per WIDTH+1 clocks.
- result and err change only on the edge that raises done.
- busy=0 in the done cycle.

## Configuration
- MONT_MOD_CHECK_EN defined:
  - An accepted start with m[0]=0 skips CALC and FINAL.
  - The next edge gives done=1, err=1, result='0; busy stays 0.
  - Latency is 1 clock.
- MONT_MOD_CHECK_EN undefined:
  - err is tied 0.
  - Even moduli run the normal WIDTH+1 schedule with an unspecified result.
- The port list is identical in both builds.

## Structure
- Package mont_pkg holds:
  - the state enum typedef (IDLE, CALC, FINAL);
  - a function returning the counter width, $clog2(WIDTH).
- Sub-module mont_csub holds the combinational conditional subtract: inputs P (WIDTH+1) and m (WIDTH), output WIDTH bits. It is instantiated once for FINAL and is reusable by the exponentiation controller.
- The top module holds the FSM, operand registers, accumulator and counter.

## Test plan
Benches use WIDTH=4, m=13 (R=16, R^-1 mod 13 = 9).
- a=5, b=7 -> done exactly 5 clocks after the accepting edge, result=3, err=0.
- a=1, b=1 -> result=9; a=0, b=11 -> result=0; a=12, b=12 -> result=9.
- start in the done cycle with a=3, b=3 -> accepted with no gap, second result=3. A start pulsed during busy is ignored: exactly two done pulses.
- rst_n low for 1 cycle during iteration 2 -> busy, done and result go 0 asynchronously with no done pulse. A following a=5, b=7 run returns 3.
- With MONT_MOD_CHECK_EN: m=12, start -> done next cycle, err=1, result=0. Without the macro, done arrives after 5 clocks with err=0.
- Randomized 2000 runs of legal odd m, a, b < m at WIDTH=8 -> result matches the reference model a·b·R^-1 mod m.
